uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmit line between NUM_REQ requesters using round-robin arbitration. Serializes each granted byte as start, data LSB-first, optional parity, and one stop bit. Bit timing comes from the external baud generator's one-cycle `tick` pulse. Sits between client logic and the `txd` pin, alongside the baud generator.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_BITS, 8, data bits per frame (5..9)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
tick  input  1  baud tick: one-clk pulse per bit period, from the baud generator
req  input  NUM_REQ  per-requester transmit request, level
data  input  NUM_REQ*DATA_BITS  per-requester byte; requester i uses bits [i*DATA_BITS +: DATA_BITS]
ack  output  NUM_REQ  one-hot, one-clk pulse when requester's byte is accepted
owner  output  OWNER_W  index of current frame's requester, OWNER_W = max(1, clog2(NUM_REQ))
busy  output  1  high while a frame is on the line
txd  output  1  serial output, idle high

Behaviour:
- Reset (async, rst=1): txd=1, busy=0, ack=0, owner=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 has top priority first).
- States: IDLE, START, DATA, [PARITY], STOP. All outputs registered.
- Acceptance occurs only on a clk edge where tick=1 and |req. Valid sources are IDLE, or STOP at its ending tick.
- Winner: first asserted req searching from pointer+1 upward, wrapping at NUM_REQ-1 to 0.
- On acceptance: latch the winner's data into the shift register, then on the next cycle:
  - pointer=winner, owner=winner
  - ack[winner]=1 for exactly one cycle
  - busy=1, txd=0, state=START
- Every tick advances exactly one bit:
  - START -> DATA, txd=bit0
  - DATA shifts LSB-first. After DATA_BITS data bits have each held for one tick period, go to PARITY if enabled, else STOP with txd=1.
  - STOP ends at its next tick. If a request is pending on that tick, accept it (back-to-back frame, no idle gap). Otherwise go to IDLE with busy=0 and txd=1.
- Each bit lasts exactly one tick period. Frame = DATA_BITS+2 ticks, or +3 with parity.
- Non-tick cycles: state, txd, and the shift register hold.
- Requesters hold req and data stable until their ack. Changes to data after ack do not affect the frame in flight.
- A req still high after ack re-enters arbitration. It is served again only after the other pending requesters (round-robin fairness).
- req without tick: nothing happens. No acceptance between ticks.
- Reset asserted mid-frame: the frame is aborted, txd=1 immediately, and no ack is reissued. The requester is not served until it re-arbitrates.
- owner holds its last value in IDLE. It is meaningful only while busy=1.

Optional Feature:
Macro UART_TX_ARB_PARITY_EN.
- Defined: a PARITY state is inserted after DATA. txd = XOR of the latched data bits (even parity), held for one tick period. Frame = DATA_BITS+3 ticks.
- Undefined: no PARITY state and no parity logic. DATA proceeds directly to STOP.

Test Plan:
- Single request: req=0001, data0=0x55, ticks every 16 clks -> ack=0001 one cycle after the first tick. txd: 0,1,0,1,0,1,0,1,0,1, each 16 clks. busy drops after the stop bit.
- Round robin: req=1111 held, each data_i=0x10+i -> frames served in order 0,1,2,3,0. ack pulses in that order. Back-to-back with no idle gap.
- Skip/wrap: after serving 2, req=0011 -> next winner 0, then 1. Requester 3 is not served.
- Reset mid-frame: assert rst during DATA bit 3 -> txd=1 and busy=0 immediately. After release, pointer=3 and req=0100 is granted on the next tick.
- No tick: req=0001 held for 100 clks with tick=0 -> ack stays 0, txd stays 1, busy stays 0.
- Parity (macro defined): data0=0x07 -> parity bit=1 before stop. data0=0x03 -> parity bit=0. Frame = 11 ticks.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmit line
// Optional even parity bit before stop when UART_TX_ARB_PARITY_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    localparam int OWNER_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [OWNER_W-1:0]           owner,
    output logic                         busy,
    output logic                         txd
);
    localparam int CNT_W = $clog2(DATA_BITS);

`ifdef UART_TX_ARB_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 state_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [OWNER_W-1:0]     owner_q;
    logic [OWNER_W-1:0]     ptr_q;
    logic                   busy_q;
    logic                   txd_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [CNT_W-1:0]       cnt_q;
`ifdef UART_TX_ARB_PARITY_EN
    logic                   parity_q;
`endif

    logic [OWNER_W-1:0]     win_d;
    logic [OWNER_W-1:0]     idx_d;
    logic                   found_d;
    logic [DATA_BITS-1:0]   win_data_d;

    // Search starts just after the last winner so every pending requester gets a turn.
    always_comb begin
        win_d   = ptr_q;
        idx_d   = ptr_q;
        found_d = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_d = OWNER_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found_d && req[idx_d]) begin
                found_d = 1'b1;
                win_d   = idx_d;
            end
        end
    end

    always_comb begin
        win_data_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_d == OWNER_W'(i)) begin
                win_data_d = data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ack_q    <= '0;
            owner_q  <= '0;
            ptr_q    <= OWNER_W'(NUM_REQ - 1);
            busy_q   <= 1'b0;
            txd_q    <= 1'b1;
            shift_q  <= '0;
            cnt_q    <= '0;
`ifdef UART_TX_ARB_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            if (tick) begin
                case (state_q)
                    // STOP shares IDLE's acceptance path so back-to-back frames have no gap.
                    S_IDLE, S_STOP: begin
                        if (|req) begin
                            shift_q        <= win_data_d;
                            ptr_q          <= win_d;
                            owner_q        <= win_d;
                            ack_q[win_d]   <= 1'b1;
                            busy_q         <= 1'b1;
                            txd_q          <= 1'b0;
                            state_q        <= S_START;
`ifdef UART_TX_ARB_PARITY_EN
                            parity_q       <= ^win_data_d;
`endif
                        end else begin
                            busy_q  <= 1'b0;
                            txd_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    S_START: begin
                        txd_q   <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= '0;
                        state_q <= S_DATA;
                    end
                    S_DATA: begin
                        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                            txd_q   <= parity_q;
                            state_q <= S_PARITY;
`else
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            txd_q   <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
`ifdef UART_TX_ARB_PARITY_EN
                    S_PARITY: begin
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end
`endif
                    default: begin
                        busy_q  <= 1'b0;
                        txd_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ack   = ack_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign txd   = txd_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - checks uart_tx_arbiter against a frame-queue model
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DB = 8;
    localparam int OW = 2;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int FRAME = DB + 3;
    localparam logic [15:0] EXP_55 = 16'h04AA;
`else
    localparam int FRAME = DB + 2;
    localparam logic [15:0] EXP_55 = 16'h02AA;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*DB-1:0] data = '0;
    logic [NR-1:0]    ack;
    logic [OW-1:0]    owner;
    logic             busy;
    logic             txd;

    int vectors = 0;
    int miscompares = 0;
    bit tick_en = 1'b0;
    int tick_per = 16;
    int tick_cnt = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .req   (req),
        .data  (data),
        .ack   (ack),
        .owner (owner),
        .busy  (busy),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!tick_en) begin
            tick_cnt = 0;
            tick = 1'b0;
        end else begin
            tick_cnt = (tick_cnt + 1) % tick_per;
            tick = (tick_cnt == 0);
        end
    end

    // Model: a frame is the list of line levels still to come; each tick moves one entry.
    int          m_ptr = NR - 1;
    bit          m_busy = 1'b0;
    bit          m_txd = 1'b1;
    logic [NR-1:0] m_ack = '0;
    int          m_owner = 0;
    bit          m_bits[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = NR - 1;
            m_busy = 1'b0;
            m_txd = 1'b1;
            m_ack = '0;
            m_owner = 0;
            m_bits.delete();
        end else begin
            m_ack = '0;
            if (tick) begin
                if (m_busy && m_bits.size() > 0) begin
                    m_txd = m_bits.pop_front();
                end else if (req != 0) begin
                    int w;
                    bit par;
                    w = -1;
                    for (int k = 1; k <= NR; k++)
                        if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
                    m_ptr = w;
                    m_owner = w;
                    m_ack[w] = 1'b1;
                    m_busy = 1'b1;
                    m_txd = 1'b0;
                    par = 1'b0;
                    for (int b = 0; b < DB; b++) begin
                        m_bits.push_back(data[w*DB + b]);
                        par ^= data[w*DB + b];
                    end
`ifdef UART_TX_ARB_PARITY_EN
                    m_bits.push_back(par);
`endif
                    m_bits.push_back(1'b1);
                end else begin
                    m_busy = 1'b0;
                    m_txd = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("txd", txd, m_txd);
            check("busy", busy, m_busy);
            check("ack", ack, m_ack);
            if (m_busy) check("owner", owner, m_owner);
        end
    end

    int got[16];
    logic [NR-1:0] gotv[16];
    int ngot = 0;

    task automatic wait_acks(input int n, input bit clr);
        int budget;
        int target;
        budget = 0;
        target = ngot + n;
        while (ngot < target && budget < 4000) begin
            @(negedge clk);
            budget++;
            if (ack != 0 && ngot < 16) begin
                got[ngot] = int'(owner);
                gotv[ngot] = ack;
                ngot++;
                if (clr) req = req & ~ack;
            end
        end
        check("ack_count", ngot, target);
    endtask

    task automatic wait_tick_edge();
        int budget;
        budget = 0;
        do begin
            @(posedge clk);
            budget++;
        end while (!tick && budget < 200);
        if (!tick) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_wait: no tick within %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        check("idle_wait", busy, 1'b0);
    endtask

    task automatic capture_frame(input int nbits, output logic [15:0] v);
        v = '0;
        v[0] = txd;
        for (int i = 1; i < nbits; i++) begin
            wait_tick_edge();
            v[i] = txd;
        end
    endtask

    initial begin
        logic [15:0] fr;
        int exp_rr[5];
        int cnt;
        exp_rr = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_ack", ack, 4'b0000);
        check("reset_owner", owner, 2'd0);
        rst = 1'b0;

        // Request without ticks must never be accepted.
        req = 4'b0001;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (ack != 0) cnt++;
        end
        check("notick_acks", cnt, 0);
        check("notick_busy", busy, 1'b0);
        check("notick_txd", txd, 1'b1);
        req = '0;

        // Round robin with all four requesting, pointer starts at 3.
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        tick_per = 4;
        tick_en = 1'b1;
        req = 4'b1111;
        ngot = 0;
        wait_acks(5, 1'b0);
        req = '0;
        for (int i = 0; i < 5; i++) check($sformatf("rr_owner%0d", i), got[i], exp_rr[i]);
        check("rr_ack0", gotv[0], 4'b0001);
        check("rr_ack3", gotv[3], 4'b1000);
        wait_idle();

        // Serve 2, then 0 and 1 requesting: wrap to 0, then 1.
        ngot = 0;
        req = 4'b0100;
        wait_acks(1, 1'b1);
        req = 4'b0011;
        wait_acks(2, 1'b1);
        check("skip_owner0", got[0], 2);
        check("skip_owner1", got[1], 0);
        check("skip_owner2", got[2], 1);
        wait_idle();

        // Single request of 0x55 with slow ticks.
        tick_en = 1'b0;
        @(negedge clk);
        data[7:0] = 8'h55;
        tick_per = 16;
        tick_en = 1'b1;
        req = 4'b0001;
        ngot = 0;
        wait_acks(1, 1'b1);
        check("single_ack", gotv[0], 4'b0001);
        capture_frame(FRAME, fr);
        check("single_frame", fr, EXP_55);
        wait_tick_edge();
        check("single_done_busy", busy, 1'b0);
        check("single_done_txd", txd, 1'b1);

        // Reset in data bit 3 aborts the frame and restores the pointer.
        tick_per = 4;
        ngot = 0;
        req = 4'b0010;
        wait_acks(1, 1'b1);
        check("rst_pre_owner", got[0], 1);
        repeat (4) wait_tick_edge();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_txd", txd, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ack", ack, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        ngot = 0;
        req = 4'b0101;
        wait_acks(2, 1'b1);
        check("rst_post_owner0", got[0], 0);
        check("rst_post_owner1", got[1], 2);
        wait_idle();

`ifdef UART_TX_ARB_PARITY_EN
        data[7:0] = 8'h07;
        ngot = 0;
        req = 4'b0001;
        wait_acks(1, 1'b1);
        capture_frame(FRAME, fr);
        check("parity_07", fr, 16'h060E);
        wait_idle();
        data[7:0] = 8'h03;
        req = 4'b0001;
        wait_acks(1, 1'b1);
        capture_frame(FRAME, fr);
        check("parity_03", fr, 16'h0406);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
